mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Two-source, packet-locked round-robin arbiter that sits directly upstream of the 2:1 select mux. It accepts two valid/ready streams (A and B) and grants one source for a whole packet, ending on `last`. It drives the mux select `sel` and presents the chosen beat through a one-stage output register. The select is held stable for the full packet, so the downstream mux never switches mid-packet.

## Interface
- `DATA_W`, default 8: payload width per source.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `a_valid` input 1: source A beat valid.
- `a_data` input DATA_W: source A payload.
- `a_last` input 1: source A final beat of packet.
- `a_ready` output 1: source A beat accepted this cycle when high with `a_valid`.
- `b_valid`, `b_data`, `b_last`, `b_ready`: same as A, for source B.
- `sel` output 1: mux select; 0 = A, 1 = B. Registered.
- `y_valid` output 1: output beat valid.
- `y_data` output DATA_W: output payload.
- `y_last` output 1: output final beat.
- `y_ready` input 1: downstream accepts the output beat.

## Operation
- FSM states: IDLE, GRANT_A, GRANT_B. Reset state is IDLE.
- Priority bit `prio` (0 favours A) resets to 0.
- IDLE transitions:
  - only `a_valid` → GRANT_A.
  - only `b_valid` → GRANT_B.
  - both → GRANT_A if `prio`=0, else GRANT_B.
  - neither → stay in IDLE.
- On entering GRANT_A, `sel` ← 0. On entering GRANT_B, `sel` ← 1. `sel` holds its value in IDLE.
- Output register can load when `load = !y_valid || y_ready`.
- Ready signals:
  - `a_ready = (state==GRANT_A) && load`.
  - `b_ready = (state==GRANT_B) && load`.
  - Both are combinational, and both are 0 in IDLE.
- Accepted beat (`x_valid && x_ready`): `y_data`, `y_last` ← source; `y_valid` ← 1.
- If `y_ready` is high and no beat is accepted, `y_valid` ← 0.
- Packet end: when an accepted beat has `last`=1:
  - state → IDLE;
  - `prio` ← 1 after an A packet, 0 after a B packet.
- Within a grant, the other source's valid is ignored. Its ready stays 0 regardless of its valid.
- Source valid dropping mid-packet: stay in the grant and wait. There is no timeout.
- Single-beat packet (`last`=1 on the first beat): one accepted beat, then IDLE.
- Reset mid-packet clears everything. The partially sent packet is truncated. Upstream restarts it.

## Timing
- Reset values:
  - `sel`=0, `y_valid`=0, `y_data`=0, `y_last`=0;
  - `a_ready`=0, `b_ready`=0 (state IDLE);
  - `prio`=0.
- Arbitration latency: a request seen in IDLE at cycle N gives a grant at N+1. The first beat can be accepted at N+1.
- Data latency: a beat accepted at cycle N appears on `y_*` from cycle N+1.
- Throughput:
  - one beat per cycle within a packet while `y_ready`=1;
  - one IDLE bubble cycle between packets.
- `sel` changes only on the IDLE → GRANT edge. It is stable for every cycle of a packet.
- Backpressure: while `y_valid && !y_ready`, the `y_*` signals hold and both readies are 0.

## Structure
- Shared package: state encoding constants (IDLE=2'd0, GRANT_A=2'd1, GRANT_B=2'd2) and the `SEL_A`/`SEL_B` select constants.
- Sub-module `out_reg_stage`: the DATA_W+1-bit valid/ready output register, exposing `load`. The FSM and priority logic stay in the top.
- `sel` feeds the existing 2:1 mux select, bit-sliced across DATA_W as needed.

## Test plan
- Reset: `rst`=1 for 2 cycles → `sel`=0, `y_valid`=0, `a_ready`=`b_ready`=0; state IDLE after release.
- A alone, 3-beat packet 0x11, 0x22, 0x33 (last on 0x33), `y_ready`=1 → grant one cycle after request. `y_data` shows 0x11, 0x22, 0x33 on consecutive cycles, `y_last` on 0x33, `sel`=0 throughout.
- A and B valid simultaneously from reset, 2-beat packets → A packet first with `sel`=0, one bubble, then B packet with `sel`=1. `prio` ends at 0.
- Continuous contention, 4 single-beat packets per source → grants alternate A, B, A, B… Output order 0xA0, 0xB0, 0xA1, 0xB1…
- Backpressure: `y_ready`=0 for 3 cycles mid-packet (A, beat 0x22 registered) → `y_data` holds 0x22, `a_ready`=0. Resume with no beat lost or duplicated.
- Reset mid-packet (B, after beat 1 of 4) → next cycle `y_valid`=0, `sel`=0, IDLE. A new A request is granted normally.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter_pkg
// Brief    : Shared state encoding, select constants and grant helper for the
//            two-source packet-locked round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mux_rr_arbiter_pkg;

    // Arbiter FSM states; explicit 2-bit encoding shared with debug tooling
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    // Mux select values driven onto sel
    localparam logic c_sel_a = 1'b0;
    localparam logic c_sel_b = 1'b1;

    // Grant decision taken in IDLE: a lone requester wins, ties go to prio
    function automatic state_t pick_grant(input logic a_req,
                                          input logic b_req,
                                          input logic prio);
        if (a_req && (!b_req || !prio)) begin
            return GRANT_A;
        end else if (b_req) begin
            return GRANT_B;
        end else begin
            return IDLE;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter_if
// Brief    : Bundle of the two source streams, the mux select and the output
//            stream of the round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mux_rr_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              a_valid;
    logic [DATA_W-1:0] a_data;
    logic              a_last;
    logic              a_ready;

    logic              b_valid;
    logic [DATA_W-1:0] b_data;
    logic              b_last;
    logic              b_ready;

    logic              sel;

    logic              y_valid;
    logic [DATA_W-1:0] y_data;
    logic              y_last;
    logic              y_ready;

    // Environment side: sources and downstream sink
    modport master (
        output a_valid, a_data, a_last,
        input  a_ready,
        output b_valid, b_data, b_last,
        input  b_ready,
        input  sel,
        input  y_valid, y_data, y_last,
        output y_ready
    );

    // Arbiter side
    modport slave (
        input  a_valid, a_data, a_last,
        output a_ready,
        input  b_valid, b_data, b_last,
        output b_ready,
        output sel,
        output y_valid, y_data, y_last,
        input  y_ready
    );

endinterface
`default_nettype wire

// File: rtl/mux_rr_arbiter_out_reg_stage.sv
`default_nettype none
// ============================================================================
// Module   : out_reg_stage
// Brief    : Single-entry valid/ready output register. Exposes o_load, the
//            condition under which a new beat may be written this cycle.
// Revision : 1.0 - initial release
// ============================================================================
module out_reg_stage #(
    parameter int WIDTH = 9
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load_en,   // beat accepted upstream
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_out_ready,
    output logic                  o_load,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Free slot when empty or when the current beat leaves this cycle
    assign o_load  = !r_valid || i_out_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Capture accepted beats; drain valid when the sink takes the beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load_en) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_out_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter
// Brief    : Two-source packet-locked round-robin arbiter in front of a 2:1
//            mux. A grant lasts a whole packet; sel only changes on the
//            IDLE -> GRANT edge, so the mux never switches mid-packet.
// Revision : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    mux_rr_arbiter_if.slave bus
);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_prio;        // 0 favours A on a tie
    logic              w_prio_next;
    logic              r_sel;
    logic              w_sel_next;

    logic              w_load;
    logic              w_a_ready;
    logic              w_b_ready;
    logic              w_accept;
    logic              w_mux_valid;
    logic              w_mux_last;
    logic [DATA_W-1:0] w_mux_data;
    logic              w_y_valid;
    logic [DATA_W:0]   w_y_payload;   // {last, data}

    // The 2:1 mux proper, select bit fanned out across the payload
    generate
        for (genvar i = 0; i < DATA_W; i++) begin : g_mux
            assign w_mux_data[i] = (r_sel == c_sel_b) ? bus.b_data[i] : bus.a_data[i];
        end
    endgenerate

    assign w_mux_valid = (r_sel == c_sel_b) ? bus.b_valid : bus.a_valid;
    assign w_mux_last  = (r_sel == c_sel_b) ? bus.b_last  : bus.a_last;

    // Readies only open for the granted source and only when the output slot is free
    assign w_a_ready = (r_state == GRANT_A) && w_load;
    assign w_b_ready = (r_state == GRANT_B) && w_load;
    assign w_accept  = w_mux_valid && (w_a_ready || w_b_ready);

    assign bus.a_ready = w_a_ready;
    assign bus.b_ready = w_b_ready;
    assign bus.sel     = r_sel;
    assign bus.y_valid = w_y_valid;
    assign bus.y_last  = w_y_payload[DATA_W];
    assign bus.y_data  = w_y_payload[DATA_W-1:0];

    out_reg_stage #(
        .WIDTH (DATA_W + 1)
    ) u_out_reg_stage (
        .clk         (clk),
        .rst         (rst),
        .i_load_en   (w_accept),
        .i_data      ({w_mux_last, w_mux_data}),
        .i_out_ready (bus.y_ready),
        .o_load      (w_load),
        .o_valid     (w_y_valid),
        .o_data      (w_y_payload)
    );

    // Next-state: arbitrate in IDLE, release the grant on an accepted last beat
    always_comb begin
        w_state_next = r_state;
        w_prio_next  = r_prio;
        w_sel_next   = r_sel;
        case (r_state)
            IDLE: begin
                w_state_next = pick_grant(bus.a_valid, bus.b_valid, r_prio);
                if (w_state_next == GRANT_A) begin
                    w_sel_next = c_sel_a;
                end else if (w_state_next == GRANT_B) begin
                    w_sel_next = c_sel_b;
                end
            end
            GRANT_A: begin
                if (w_accept && w_mux_last) begin
                    w_state_next = IDLE;
                    w_prio_next  = 1'b1;
                end
            end
            GRANT_B: begin
                if (w_accept && w_mux_last) begin
                    w_state_next = IDLE;
                    w_prio_next  = 1'b0;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State, priority and select registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_prio  <= 1'b0;
            r_sel   <= c_sel_a;
        end else begin
            r_state <= w_state_next;
            r_prio  <= w_prio_next;
            r_sel   <= w_sel_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_rr_arbiter
// Brief    : Self-checking bench for mux_rr_arbiter. Source beats and the
//            expected output order come from a vector table; expected beats
//            sit in a scoreboard queue and are popped as the DUT emits them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;

    localparam int DATA_W = 8;
    localparam int N_VEC  = 23;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.DATA_W(DATA_W)) bus ();

    mux_rr_arbiter #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          scen;
        logic        src;       // 0 = A, 1 = B
        logic [7:0]  data;
        logic        last;
        logic [7:0]  exp_data;  // expected output beat at this position
        logic        exp_last;
        logic        chk;       // push expectation to scoreboard
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    vec_t  tbl [0:N_VEC-1];
    beat_t qa[$];
    beat_t qb[$];
    beat_t sb[$];

    int ntests = 0;
    int nfail  = 0;
    int cyc, first_a, first_b, first_out, last_out, b_cnt;
    int bp_cnt;
    logic bp_en, bp_done;
    logic [7:0] bp_trig;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle, entered and left at posedge+1
    task automatic cycle();
        logic acc_a, acc_b, acc_y, stall;
        beat_t e;
        bus.a_valid = (qa.size() != 0);
        bus.a_data  = (qa.size() != 0) ? qa[0].data : 8'h00;
        bus.a_last  = (qa.size() != 0) ? qa[0].last : 1'b0;
        bus.b_valid = (qb.size() != 0);
        bus.b_data  = (qb.size() != 0) ? qb[0].data : 8'h00;
        bus.b_last  = (qb.size() != 0) ? qb[0].last : 1'b0;
        if (bp_en && !bp_done && bus.y_valid && bus.y_data == bp_trig) begin
            bp_cnt  = 3;
            bp_done = 1'b1;
        end
        stall = (bp_cnt > 0);
        bus.y_ready = !stall;
        if (bp_cnt > 0) bp_cnt--;
        #1;
        acc_a = bus.a_valid && bus.a_ready;
        acc_b = bus.b_valid && bus.b_ready;
        acc_y = bus.y_valid && bus.y_ready;
        if (bus.a_valid && bus.b_valid)
            check("excl_ready", {31'd0, bus.a_ready && bus.b_ready}, 32'd0);
        if (acc_a) begin
            check("sel_during_a", {31'd0, bus.sel}, 32'd0);
            if (first_a < 0) first_a = cyc;
        end
        if (acc_b) begin
            check("sel_during_b", {31'd0, bus.sel}, 32'd1);
            if (first_b < 0) first_b = cyc;
            b_cnt++;
        end
        if (stall) begin
            check("bp_hold_data", {24'd0, bus.y_data}, {24'd0, bp_trig});
            check("bp_a_ready", {31'd0, bus.a_ready}, 32'd0);
        end
        if (acc_y) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_beat", {24'd0, bus.y_data}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("y_data", {24'd0, bus.y_data}, {24'd0, e.data});
                check("y_last", {31'd0, bus.y_last}, {31'd0, e.last});
            end
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
        end
        @(posedge clk);
        #1;
        if (acc_a) void'(qa.pop_front());
        if (acc_b) void'(qb.pop_front());
        cyc++;
    endtask

    task automatic run_scen(input int id, input int limit, input int stop_b);
        beat_t b;
        cyc = 0; first_a = -1; first_b = -1; first_out = -1; last_out = -1; b_cnt = 0;
        for (int i = 0; i < N_VEC; i++) begin
            if (tbl[i].scen == id) begin
                b.data = tbl[i].data;
                b.last = tbl[i].last;
                if (tbl[i].src) qb.push_back(b); else qa.push_back(b);
                if (tbl[i].chk) begin
                    b.data = tbl[i].exp_data;
                    b.last = tbl[i].exp_last;
                    sb.push_back(b);
                end
            end
        end
        while ((qa.size() != 0 || qb.size() != 0 || sb.size() != 0) &&
               !(stop_b > 0 && b_cnt >= stop_b)) begin
            if (cyc >= limit) begin
                ntests++;
                nfail++;
                $display("FAIL timeout_scen%0d: got %0d cycles expected < %0d", id, cyc, limit);
                qa.delete(); qb.delete(); sb.delete();
                break;
            end
            cycle();
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{2, 1'b0, 8'h11, 1'b0, 8'h11, 1'b0, 1'b1};
        tbl[1]  = '{2, 1'b0, 8'h22, 1'b0, 8'h22, 1'b0, 1'b1};
        tbl[2]  = '{2, 1'b0, 8'h33, 1'b1, 8'h33, 1'b1, 1'b1};
        tbl[3]  = '{3, 1'b0, 8'h31, 1'b0, 8'h31, 1'b0, 1'b1};
        tbl[4]  = '{3, 1'b0, 8'h32, 1'b1, 8'h32, 1'b1, 1'b1};
        tbl[5]  = '{3, 1'b1, 8'h41, 1'b0, 8'h41, 1'b0, 1'b1};
        tbl[6]  = '{3, 1'b1, 8'h42, 1'b1, 8'h42, 1'b1, 1'b1};
        tbl[7]  = '{4, 1'b0, 8'hA0, 1'b1, 8'hA0, 1'b1, 1'b1};
        tbl[8]  = '{4, 1'b0, 8'hA1, 1'b1, 8'hB0, 1'b1, 1'b1};
        tbl[9]  = '{4, 1'b0, 8'hA2, 1'b1, 8'hA1, 1'b1, 1'b1};
        tbl[10] = '{4, 1'b0, 8'hA3, 1'b1, 8'hB1, 1'b1, 1'b1};
        tbl[11] = '{4, 1'b1, 8'hB0, 1'b1, 8'hA2, 1'b1, 1'b1};
        tbl[12] = '{4, 1'b1, 8'hB1, 1'b1, 8'hB2, 1'b1, 1'b1};
        tbl[13] = '{4, 1'b1, 8'hB2, 1'b1, 8'hA3, 1'b1, 1'b1};
        tbl[14] = '{4, 1'b1, 8'hB3, 1'b1, 8'hB3, 1'b1, 1'b1};
        tbl[15] = '{5, 1'b0, 8'h11, 1'b0, 8'h11, 1'b0, 1'b1};
        tbl[16] = '{5, 1'b0, 8'h22, 1'b0, 8'h22, 1'b0, 1'b1};
        tbl[17] = '{5, 1'b0, 8'h33, 1'b1, 8'h33, 1'b1, 1'b1};
        tbl[18] = '{6, 1'b1, 8'hC1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[19] = '{6, 1'b1, 8'hC2, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[20] = '{6, 1'b1, 8'hC3, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[21] = '{6, 1'b1, 8'hC4, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[22] = '{7, 1'b0, 8'h5A, 1'b1, 8'h5A, 1'b1, 1'b1};

        bp_en = 1'b0; bp_done = 1'b0; bp_cnt = 0; bp_trig = 8'h00;
        bus.a_valid = 1'b0; bus.a_data = '0; bus.a_last = 1'b0;
        bus.b_valid = 1'b0; bus.b_data = '0; bus.b_last = 1'b0;
        bus.y_ready = 1'b1;

        // Reset held for two cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sel",     {31'd0, bus.sel},     32'd0);
        check("rst_y_valid", {31'd0, bus.y_valid}, 32'd0);
        check("rst_y_data",  {24'd0, bus.y_data},  32'd0);
        check("rst_y_last",  {31'd0, bus.y_last},  32'd0);
        check("rst_a_ready", {31'd0, bus.a_ready}, 32'd0);
        check("rst_b_ready", {31'd0, bus.b_ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_a_ready", {31'd0, bus.a_ready}, 32'd0);
        check("idle_y_valid", {31'd0, bus.y_valid}, 32'd0);

        // A alone, 3-beat packet
        run_scen(2, 40, 0);
        check("s2_grant_latency", first_a,   1);
        check("s2_first_out",     first_out, 2);
        check("s2_last_out",      last_out,  4);

        // Both valid straight out of reset
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_scen(3, 40, 0);
        check("s3_first_a", first_a, 1);
        check("s3_first_b_bubble", first_b, 4);
        check("s3_last_out", last_out, 6);

        // Continuous contention, single-beat packets alternate
        run_scen(4, 60, 0);
        check("s4_first_a", first_a, 1);
        check("s4_first_b", first_b, 3);
        check("s4_last_out", last_out, 16);

        // Backpressure for three cycles while 0x22 is registered
        bp_en = 1'b1; bp_done = 1'b0; bp_trig = 8'h22;
        run_scen(5, 40, 0);
        bp_en = 1'b0;
        check("s5_bp_taken", {31'd0, bp_done}, 32'd1);
        check("s5_last_out", last_out, 7);

        // Reset after the first beat of a 4-beat B packet
        run_scen(6, 40, 1);
        check("s6_sel_before_rst", {31'd0, bus.sel},     32'd1);
        check("s6_y_before_rst",   {31'd0, bus.y_valid}, 32'd1);
        qa.delete(); qb.delete(); sb.delete();
        bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.y_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("s6_rst_y_valid", {31'd0, bus.y_valid}, 32'd0);
        check("s6_rst_sel",     {31'd0, bus.sel},     32'd0);
        check("s6_rst_a_ready", {31'd0, bus.a_ready}, 32'd0);
        check("s6_rst_b_ready", {31'd0, bus.b_ready}, 32'd0);
        rst = 1'b0;

        // New A request after the truncated packet
        run_scen(7, 40, 0);
        check("s7_grant_latency", first_a,   1);
        check("s7_last_out",      last_out,  2);
        check("s7_final_sel",     {31'd0, bus.sel}, 32'd0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
